// File: rtl/iiitb_rv32i_pkg.sv
// rtl/iiitb_rv32i_pkg.sv - shared constants for the iiitb_rv32i GPIO output stage
// Contents: default data width, FIFO depth, hold length, pad output-enable-bar levels.
package iiitb_rv32i_pkg;

    localparam int   GPIO_DATA_W      = 16;
    localparam int   GPIO_FIFO_DEPTH  = 4;
    localparam int   GPIO_HOLD_CYCLES = 8;
    localparam logic GPIO_OEB_OUT     = 1'b0;
    localparam logic GPIO_OEB_IN      = 1'b1;

endpackage

// File: rtl/iiitb_rv32i_sync_fifo.sv
// rtl/iiitb_rv32i_sync_fifo.sv - synchronous FIFO with occupancy count for the GPIO output stage
// Ports:
//   wb_clk_i, wb_rst_i  clock, asynchronous active-high reset
//   i_push_valid/i_push_data/o_push_ready  write handshake
//   i_pop               remove the head entry (ignored when empty)
//   o_head              head entry, valid while o_empty is low
//   o_level, o_empty    occupancy
module iiitb_rv32i_sync_fifo #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_i,
    input  logic                     i_push_valid,
    input  logic [DATA_W-1:0]        i_push_data,
    output logic                     o_push_ready,
    input  logic                     i_pop,
    output logic [DATA_W-1:0]        o_head,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_rptr;
    logic [LVL_W-1:0]  r_count;
    logic              w_push;
    logic              w_pop;

    // Ready comes only from the count register, so a full FIFO refuses a
    // push even when a pop frees a slot on the same edge.
    assign o_push_ready = (r_count < LVL_W'(DEPTH));
    assign o_empty      = (r_count == '0);
    assign o_level      = r_count;
    assign o_head       = r_mem[r_rptr];

    assign w_push = i_push_valid && o_push_ready;
    assign w_pop  = i_pop && !o_empty;

    always_ff @(posedge wb_clk_i) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_push_data;
        end
    end

    // Power-of-two depth lets the pointers wrap by natural overflow.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + LVL_W'(1);
                2'b01:   r_count <= r_count - LVL_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/iiitb_rv32i_gpio_out.sv
// rtl/iiitb_rv32i_gpio_out.sv - buffered, held output of core store values onto mprj_io[23:8]
// Build option: IIITB_GPIO_HOLD_EN enables the per-value hold counter (HOLD_CYCLES);
// without it every buffered value is presented for exactly one cycle.
// Ports:
//   wb_clk_i, wb_rst_i        clock, asynchronous active-high reset
//   wr_valid_i/wr_data_i/wr_ready_o  store handshake from the core
//   io_out, io_oeb            pad data and output-enable-bar (0 = drive)
//   level_o                   FIFO occupancy
//   busy_o                    values still pending or being held
module iiitb_rv32i_gpio_out
    import iiitb_rv32i_pkg::*;
#(
    parameter int DATA_W      = GPIO_DATA_W,
    parameter int DEPTH       = GPIO_FIFO_DEPTH,
    parameter int HOLD_CYCLES = GPIO_HOLD_CYCLES
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_i,
    input  logic                   wr_valid_i,
    input  logic [DATA_W-1:0]      wr_data_i,
    output logic                   wr_ready_o,
    output logic [DATA_W-1:0]      io_out,
    output logic [DATA_W-1:0]      io_oeb,
    output logic [$clog2(DEPTH):0] level_o,
    output logic                   busy_o
);

    logic [DATA_W-1:0] w_head;
    logic              w_empty;
    logic              w_pop;
    logic              w_hold_zero;
    logic [DATA_W-1:0] r_out;
    logic              r_driven;

    iiitb_rv32i_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .wb_clk_i     (wb_clk_i),
        .wb_rst_i     (wb_rst_i),
        .i_push_valid (wr_valid_i),
        .i_push_data  (wr_data_i),
        .o_push_ready (wr_ready_o),
        .i_pop        (w_pop),
        .o_head       (w_head),
        .o_level      (level_o),
        .o_empty      (w_empty)
    );

    assign w_pop = !w_empty && w_hold_zero;

`ifdef IIITB_GPIO_HOLD_EN
    localparam int HOLD_W = $clog2(HOLD_CYCLES) + 1;

    logic [HOLD_W-1:0] r_hold_cnt;

    // Loading HOLD_CYCLES-1 on the pop edge plus the pop-eligible cycle at 0
    // spaces successive output changes exactly HOLD_CYCLES edges apart.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_hold_cnt <= '0;
        end else if (w_pop) begin
            r_hold_cnt <= HOLD_W'(HOLD_CYCLES - 1);
        end else if (r_hold_cnt != '0) begin
            r_hold_cnt <= r_hold_cnt - HOLD_W'(1);
        end
    end

    assign w_hold_zero = (r_hold_cnt == '0);
`else
    logic w_unused_hold;

    assign w_unused_hold = (HOLD_CYCLES != 0);
    assign w_hold_zero   = 1'b1;
`endif

    assign busy_o = !w_empty || !w_hold_zero;

    // The pad keeps the last value after the FIFO drains; only reset clears it.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_out    <= '0;
            r_driven <= 1'b0;
        end else if (w_pop) begin
            r_out    <= w_head;
            r_driven <= 1'b1;
        end
    end

    assign io_out = r_out;
    assign io_oeb = r_driven ? {DATA_W{GPIO_OEB_OUT}} : {DATA_W{GPIO_OEB_IN}};

endmodule

// File: tb/tb_iiitb_rv32i_gpio_out.sv
// tb/tb_iiitb_rv32i_gpio_out.sv - self-checking bench for iiitb_rv32i_gpio_out
module tb_iiitb_rv32i_gpio_out;

    localparam int DEPTH = 4;
`ifdef IIITB_GPIO_HOLD_EN
    localparam int HOLD = 8;
`else
    localparam int HOLD = 1;
`endif

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i = 1'b0;
    logic        wr_valid_i = 1'b0;
    logic [15:0] wr_data_i = '0;
    logic        wr_ready_o;
    logic [15:0] io_out;
    logic [15:0] io_oeb;
    logic [2:0]  level_o;
    logic        busy_o;

    iiitb_rv32i_gpio_out dut (
        .wb_clk_i   (wb_clk_i),
        .wb_rst_i   (wb_rst_i),
        .wr_valid_i (wr_valid_i),
        .wr_data_i  (wr_data_i),
        .wr_ready_o (wr_ready_o),
        .io_out     (io_out),
        .io_oeb     (io_oeb),
        .level_o    (level_o),
        .busy_o     (busy_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    int checks = 0;
    int errors = 0;

    // Reference model: pending values in a queue, remaining hold as an integer.
    logic [15:0] q[$];
    int          m_hold;
    logic [15:0] m_out;
    bit          m_driven;
    bit          m_pushed;

    function automatic void model_reset();
        q.delete();
        m_hold   = 0;
        m_out    = '0;
        m_driven = 1'b0;
    endfunction

    function automatic logic [15:0] exp_oeb();
        return m_driven ? 16'h0000 : 16'hFFFF;
    endfunction

    // Drive one cycle, advance the model across the edge, settle 1 time unit.
    task automatic tick(input logic v, input logic [15:0] d);
        bit pop;
        wr_valid_i = v;
        wr_data_i  = d;
        @(posedge wb_clk_i);
        pop      = (q.size() != 0) && (m_hold == 0);
        m_pushed = v && (q.size() < DEPTH);
        if (pop) begin
            m_out    = q.pop_front();
            m_hold   = HOLD - 1;
            m_driven = 1'b1;
        end else if (m_hold > 0) begin
            m_hold--;
        end
        if (m_pushed) q.push_back(d);
        #1;
    endtask

    task automatic do_reset();
        #2 wb_rst_i = 1'b1;
        model_reset();
        @(posedge wb_clk_i);
        #1 wb_rst_i = 1'b0;
        wr_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        #2 wb_rst_i = 1'b1;
        #1;
        model_reset();
        checks++; if (io_out !== 16'h0000) begin errors++; $display("FAIL reset_io_out got %h exp 0000", io_out); end
        checks++; if (io_oeb !== 16'hFFFF) begin errors++; $display("FAIL reset_io_oeb got %h exp ffff", io_oeb); end
        checks++; if (level_o !== 3'd0) begin errors++; $display("FAIL reset_level got %0d exp 0", level_o); end
        checks++; if (wr_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", wr_ready_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy_o); end
        @(posedge wb_clk_i);
        @(posedge wb_clk_i);
        #1 wb_rst_i = 1'b0;
    endtask

    task automatic test_single();
        int e = 0;
        tick(1'b1, 16'd1);
        checks++; if (io_out !== m_out) begin errors++; $display("FAIL single_push_edge_out got %h exp %h", io_out, m_out); end
        checks++; if (level_o !== 3'(q.size())) begin errors++; $display("FAIL single_push_edge_level got %0d exp %0d", level_o, q.size()); end
        while (e < 50) begin
            tick(1'b0, 16'd0);
            e++;
            if (e == 1) begin
                checks++; if (io_out !== 16'd1) begin errors++; $display("FAIL single_out got %h exp 0001", io_out); end
                checks++; if (io_oeb !== 16'h0000) begin errors++; $display("FAIL single_oeb got %h exp 0000", io_oeb); end
            end
            checks++; if (busy_o !== ((q.size() != 0) || (m_hold != 0))) begin errors++; $display("FAIL single_busy got %b at edge %0d", busy_o, e); end
            if (busy_o === 1'b0) break;
        end
        checks++; if (e != HOLD) begin errors++; $display("FAIL single_busy_fall got edge %0d exp %0d", e, HOLD); end
    endtask

    task automatic test_burst();
        logic [15:0] nxt = 16'd1;
        logic [15:0] prev;
        logic [15:0] obs_val[$];
        int          obs_cyc[$];
        int          cyc = 0;
        do_reset();
        prev = io_out;
        while (cyc < 400 && !(nxt > 16'd16 && q.size() == 0 && m_hold == 0)) begin
            tick(nxt <= 16'd16, nxt);
            cyc++;
            if (m_pushed) nxt++;
            checks++; if (io_out !== m_out) begin errors++; $display("FAIL burst_out got %h exp %h cyc %0d", io_out, m_out, cyc); end
            checks++; if (level_o !== 3'(q.size())) begin errors++; $display("FAIL burst_level got %0d exp %0d cyc %0d", level_o, q.size(), cyc); end
            checks++; if (wr_ready_o !== (q.size() < DEPTH)) begin errors++; $display("FAIL burst_ready got %b cyc %0d", wr_ready_o, cyc); end
            checks++; if (io_oeb !== exp_oeb()) begin errors++; $display("FAIL burst_oeb got %h exp %h", io_oeb, exp_oeb()); end
            if (io_out !== prev) begin
                obs_val.push_back(io_out);
                obs_cyc.push_back(cyc);
                prev = io_out;
            end
        end
        checks++; if (cyc >= 400) begin errors++; $display("FAIL burst_timeout got %0d cycles exp <400", cyc); end
        checks++; if (obs_val.size() != 16) begin errors++; $display("FAIL burst_count got %0d exp 16", obs_val.size()); end
        for (int i = 0; i < obs_val.size(); i++) begin
            checks++; if (obs_val[i] !== 16'(i + 1)) begin errors++; $display("FAIL burst_order got %h exp %h", obs_val[i], 16'(i + 1)); end
            if (i > 0) begin
                checks++; if (obs_cyc[i] - obs_cyc[i-1] != HOLD) begin errors++; $display("FAIL burst_gap got %0d exp %0d", obs_cyc[i] - obs_cyc[i-1], HOLD); end
            end
        end
    endtask

    task automatic test_full_boundary();
        do_reset();
        for (int c = 0; c < 40; c++) begin
            tick(1'b1, 16'($urandom));
            checks++; if (level_o !== 3'(q.size())) begin errors++; $display("FAIL full_level got %0d exp %0d", level_o, q.size()); end
            checks++; if (wr_ready_o !== (q.size() < DEPTH)) begin errors++; $display("FAIL full_ready got %b exp %b", wr_ready_o, q.size() < DEPTH); end
            checks++; if (io_out !== m_out) begin errors++; $display("FAIL full_out got %h exp %h", io_out, m_out); end
        end
    endtask

    task automatic test_reset_mid_burst();
        int pushed = 0;
        int guard = 0;
        do_reset();
        while (pushed < 6 && guard < 200) begin
            tick(1'b1, 16'(16'h0100 + pushed));
            guard++;
            if (m_pushed) pushed++;
        end
        checks++; if (pushed != 6) begin errors++; $display("FAIL rst_mid_fill got %0d exp 6", pushed); end
        #2 wb_rst_i = 1'b1;
        #1;
        model_reset();
        checks++; if (io_out !== 16'h0000) begin errors++; $display("FAIL rst_mid_out got %h exp 0000", io_out); end
        checks++; if (io_oeb !== 16'hFFFF) begin errors++; $display("FAIL rst_mid_oeb got %h exp ffff", io_oeb); end
        checks++; if (level_o !== 3'd0) begin errors++; $display("FAIL rst_mid_level got %0d exp 0", level_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got %b exp 0", busy_o); end
        @(posedge wb_clk_i);
        #1 wb_rst_i = 1'b0;
        tick(1'b1, 16'h00AA);
        tick(1'b0, 16'h0000);
        checks++; if (io_out !== 16'h00AA) begin errors++; $display("FAIL rst_mid_after got %h exp 00aa", io_out); end
        checks++; if (level_o !== 3'd0) begin errors++; $display("FAIL rst_mid_after_level got %0d exp 0", level_o); end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 500; c++) begin
            tick($urandom_range(0, 3) == 0, 16'($urandom));
            checks++; if (io_out !== m_out) begin errors++; $display("FAIL rand_out got %h exp %h cyc %0d", io_out, m_out, c); end
            checks++; if (io_oeb !== exp_oeb()) begin errors++; $display("FAIL rand_oeb got %h exp %h", io_oeb, exp_oeb()); end
            checks++; if (level_o !== 3'(q.size())) begin errors++; $display("FAIL rand_level got %0d exp %0d", level_o, q.size()); end
            checks++; if (wr_ready_o !== (q.size() < DEPTH)) begin errors++; $display("FAIL rand_ready got %b", wr_ready_o); end
            checks++; if (busy_o !== ((q.size() != 0) || (m_hold != 0))) begin errors++; $display("FAIL rand_busy got %b", busy_o); end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_burst();
        test_full_boundary();
        test_reset_mid_burst();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
